// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life row stepper.
package life_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int NEIGHBOUR_COUNT_WIDTH = 4;

    localparam logic [NEIGHBOUR_COUNT_WIDTH-1:0] SURVIVE_LO = 4'd2;
    localparam logic [NEIGHBOUR_COUNT_WIDTH-1:0] SURVIVE_HI = 4'd3;
    localparam logic [NEIGHBOUR_COUNT_WIDTH-1:0] BIRTH      = 4'd3;

    // Next-generation state of one cell from its current state and live-neighbour count.
    function automatic logic apply_rule(input logic alive,
                                        input logic [NEIGHBOUR_COUNT_WIDTH-1:0] count);
        if (alive)
            return (count >= SURVIVE_LO) && (count <= SURVIVE_HI);
        else
            return count == BIRTH;
    endfunction

endpackage

// File: rtl/full_adder_extending.sv
// One-bit full adder cell; the carry out extends the result by one bit.
module full_adder_extending (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain sum/carry of three equal-weight bits.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/life_cell_rule.sv
// Combinational Game-of-Life rule for one cell: counts the eight neighbour
// bits with a full-adder tree and applies the survive/birth rule.
module life_cell_rule
    import life_pkg::*;
(
    input  logic [7:0] neighbours,
    input  logic       alive,
    output logic       next_alive
);

    logic s0, s1, s2, c0, c1, c2;
    logic c3, s4, c4, c5;
    logic [NEIGHBOUR_COUNT_WIDTH-1:0] count;

    // Weight-1 layer: three groups of neighbours reduced to three sums and three carries.
    full_adder_extending u_fa_a (.a(neighbours[0]), .b(neighbours[1]), .cin(neighbours[2]), .sum(s0), .cout(c0));
    full_adder_extending u_fa_b (.a(neighbours[3]), .b(neighbours[4]), .cin(neighbours[5]), .sum(s1), .cout(c1));
    full_adder_extending u_fa_c (.a(neighbours[6]), .b(neighbours[7]), .cin(1'b0),          .sum(s2), .cout(c2));
    full_adder_extending u_fa_d (.a(s0),            .b(s1),            .cin(s2),            .sum(count[0]), .cout(c3));

    // Weight-2 layer: four carries reduced to bit 1 plus two weight-4 carries.
    full_adder_extending u_fa_e (.a(c0), .b(c1), .cin(c2),   .sum(s4),       .cout(c4));
    full_adder_extending u_fa_f (.a(s4), .b(c3), .cin(1'b0), .sum(count[1]), .cout(c5));

    // Weight-4 layer: two carries give bits 2 and 3 (count tops out at 8).
    full_adder_extending u_fa_g (.a(c4), .b(c5), .cin(1'b0), .sum(count[2]), .cout(count[3]));

    // Survive/birth decision on the finished count.
    always_comb begin
        next_alive = apply_rule(alive, count);
    end

endmodule

// File: rtl/life_row_stepper.sv
// Streaming Game-of-Life stepper: takes one grid row per beat, keeps the
// previous and current rows, and emits the next generation of the current
// row once the row below it arrives (or a dead row at the frame bottom).
//
// state | meaning
// EMPTY | no rows of the current frame held; next row is the top row
// HOLD  | prev/curr valid; next accepted row lets curr be evaluated
// FLUSH | bottom row received; emit its next generation against a dead row below
module life_row_stepper
    import life_pkg::*;
#(
    parameter int GRID_WIDTH      = 8,
    parameter int GEN_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [GRID_WIDTH-1:0]      in_row,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [GRID_WIDTH-1:0]      out_row,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [GEN_COUNT_WIDTH-1:0] gen_count
);

    state_t                state;
    logic [GRID_WIDTH-1:0] prev;
    logic [GRID_WIDTH-1:0] curr;
    logic [GRID_WIDTH-1:0] below;
    logic [GRID_WIDTH-1:0] next_row;
    logic [GRID_WIDTH+1:0] prev_pad;
    logic [GRID_WIDTH+1:0] curr_pad;
    logic [GRID_WIDTH+1:0] below_pad;
    logic                  slot_free;
    logic                  in_fire;

    // Handshake terms and the row beneath curr (dead once the frame has ended).
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && (state != FLUSH);
        in_fire   = in_valid && in_ready;
        below     = (state == FLUSH) ? '0 : in_row;
        prev_pad  = {1'b0, prev,  1'b0};
        curr_pad  = {1'b0, curr,  1'b0};
        below_pad = {1'b0, below, 1'b0};
    end

    // Column i sits at padded index i+1; the zero pads make off-grid neighbours dead.
    for (genvar i = 0; i < GRID_WIDTH; i++) begin : g_cell
        life_cell_rule u_rule (
            .neighbours ({prev_pad[i+2],  prev_pad[i+1],  prev_pad[i],
                          curr_pad[i+2],                  curr_pad[i],
                          below_pad[i+2], below_pad[i+1], below_pad[i]}),
            .alive      (curr_pad[i+1]),
            .next_alive (next_row[i])
        );
    end

    // Row-window FSM with the single-entry output register and generation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            prev      <= '0;
            curr      <= '0;
            out_row   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            gen_count <= '0;
        end else begin
            if (out_valid && out_ready && out_last)
                gen_count <= gen_count + GEN_COUNT_WIDTH'(1);

            // A load below overrides this clear, so a consume-and-refill keeps out_valid high.
            if (out_ready)
                out_valid <= 1'b0;

            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        curr  <= in_row;
                        prev  <= '0;
                        state <= in_last ? FLUSH : HOLD;
                    end
                end
                HOLD: begin
                    if (in_fire) begin
                        out_row   <= next_row;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        prev      <= curr;
                        curr      <= in_row;
                        state     <= in_last ? FLUSH : HOLD;
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        out_row   <= next_row;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        prev      <= '0;
                        curr      <= '0;
                        state     <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_life_row_stepper.sv
// Directed bench for life_row_stepper: blinker, corner block, single-row
// frame, backpressure, asynchronous reset mid-frame and counter wrap.
module tb_life_row_stepper;

    localparam int W  = 8;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_row;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [W-1:0]  out_row;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [GW-1:0] gen_count;

    int errors = 0;
    int checks = 0;

    logic [W:0] got_q[$];
    logic [W:0] exp_q[$];

    life_row_stepper #(.GRID_WIDTH(W), .GEN_COUNT_WIDTH(GW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_row    (in_row),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    // Record every row that will handshake at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            got_q.push_back({out_last, out_row});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Present one row and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [W-1:0] row, input logic last);
        logic accepted;
        accepted = 1'b0;
        in_row   = row;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic send_blinker();
        send(8'b00000000, 1'b0);
        send(8'b00001000, 1'b0);
        send(8'b00001000, 1'b0);
        send(8'b00001000, 1'b0);
        send(8'b00000000, 1'b1);
    endtask

    // Wait for n recorded rows, then step past the handshake edge of the last one.
    task automatic wait_rows(input int n);
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s_row%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        end
    endtask

    initial begin
        logic [W-1:0]  held;
        logic          seen;
        logic [GW-1:0] exp_gen;

        rst       = 1'b1;
        in_row    = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_row",   out_row,   8'h00);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_gen_count", gen_count, 2'd0);
        check("rst_in_ready",  in_ready,  1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Blinker, free-running output
        got_q.delete();
        send_blinker();
        wait_rows(5);
        exp_q = '{{1'b0, 8'h00}, {1'b0, 8'h00}, {1'b0, 8'h1C}, {1'b0, 8'h00}, {1'b1, 8'h00}};
        check_frame("blinker");
        check("blinker_gen", gen_count, 2'd1);

        // Corner block still-life
        apply_reset();
        send(8'b11000000, 1'b0);
        send(8'b11000000, 1'b1);
        wait_rows(2);
        exp_q = '{{1'b0, 8'hC0}, {1'b1, 8'hC0}};
        check_frame("corner");

        // Single-row frame
        apply_reset();
        send(8'b11100000, 1'b1);
        @(negedge clk);
        check("single_flush_in_ready",  in_ready,  1'b0);
        check("single_flush_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check("single_out_valid", out_valid, 1'b1);
        check("single_out_row",   out_row,   8'h40);
        check("single_out_last",  out_last,  1'b1);
        @(posedge clk);
        #1;
        check("single_empty_in_ready", in_ready,  1'b1);
        check("single_gen",            gen_count, 2'd1);

        // Backpressure during the blinker
        apply_reset();
        out_ready = 1'b0;
        fork
            send_blinker();
            begin
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("bp_first_valid", {31'd0, seen}, 32'd1);
                held = out_row;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_hold_row",      out_row,   held);
                    check("bp_hold_valid",    out_valid, 1'b1);
                    check("bp_hold_in_ready", in_ready,  1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_rows(5);
        exp_q = '{{1'b0, 8'h00}, {1'b0, 8'h00}, {1'b0, 8'h1C}, {1'b0, 8'h00}, {1'b1, 8'h00}};
        check_frame("bp");
        check("bp_gen", gen_count, 2'd1);

        // Asynchronous reset mid-frame (gen_count is 1 going in)
        send(8'b00000000, 1'b0);
        send(8'b00001000, 1'b0);
        check("mid_pre_valid", out_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_row",   out_row,   8'h00);
        check("mid_rst_out_last",  out_last,  1'b0);
        check("mid_rst_gen",       gen_count, 2'd0);
        check("mid_rst_in_ready",  in_ready,  1'b1);
        #1 rst = 1'b0;
        got_q.delete();
        send_blinker();
        wait_rows(5);
        exp_q = '{{1'b0, 8'h00}, {1'b0, 8'h00}, {1'b0, 8'h1C}, {1'b0, 8'h00}, {1'b1, 8'h00}};
        check_frame("mid");
        check("mid_gen", gen_count, 2'd1);

        // Generation counter wrap on a 2-bit counter
        apply_reset();
        exp_gen = 2'd0;
        for (int f = 0; f < 5; f++) begin
            send(8'b00000000, 1'b1);
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (out_valid && out_ready && out_last) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("wrap_last_seen", {31'd0, seen}, 32'd1);
            @(posedge clk);
            #1;
            exp_gen = exp_gen + 2'd1;
            check($sformatf("wrap_gen%0d", f), gen_count, exp_gen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
